mm_job_sequencer: RTL and testbench

MM_JOB_SEQUENCER -- requirements
Module: mm_job_sequencer

---
 rtl/mm_job_sequencer_pkg.sv | 26 ++
 rtl/mm_job_sequencer_if.sv | 36 +++
 rtl/mm_job_sequencer_seq_word_buf.sv | 39 +++
 rtl/mm_job_sequencer.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mm_job_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_job_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mm_job_sequencer_pkg
// Shared definitions for the memory-mapped job sequencer:
//   - seq_state_t : 4-bit FSM state encoding
//   - STAT_*      : bit positions inside status_port
//   - CMD_*       : field positions inside command_port
// ---------------------------------------------------------------------------
package mm_job_sequencer_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_READ  = 4'd1,
        S_FLUSH = 4'd2,
        S_WRITE = 4'd3,
        S_DONE  = 4'd4
    } seq_state_t;

    localparam int STAT_ACK    = 0;
    localparam int STAT_BUSY   = 1;
    localparam int STAT_ERR    = 2;

    localparam int CMD_REQ     = 0;
    localparam int CMD_LEN_LSB = 8;
    localparam int CMD_LEN_MSB = 15;

endpackage

// File: rtl/mm_job_sequencer_if.sv
// ---------------------------------------------------------------------------
// mm_job_sequencer_if
// Avalon-MM master bus used by the job sequencer.
//   master_address     : byte address (ADDR_W bits)
//   master_read/write  : transfer strobes
//   master_readdata    : read return data
//   master_writedata   : write data
//   master_waitrequest : slave stall, transfer completes when low
//   master_byteen      : byte enables
// Modports: master (sequencer side), slave (memory side).
// ---------------------------------------------------------------------------
interface mm_job_sequencer_if #(
    parameter int ADDR_W = 10
) ();

    logic [ADDR_W-1:0] master_address;
    logic              master_read;
    logic              master_write;
    logic [31:0]       master_readdata;
    logic [31:0]       master_writedata;
    logic              master_waitrequest;
    logic [3:0]        master_byteen;

    modport master (
        output master_address, master_read, master_write,
               master_writedata, master_byteen,
        input  master_readdata, master_waitrequest
    );

    modport slave (
        input  master_address, master_read, master_write,
               master_writedata, master_byteen,
        output master_readdata, master_waitrequest
    );

endinterface

// File: rtl/mm_job_sequencer_seq_word_buf.sv
// ---------------------------------------------------------------------------
// seq_word_buf
// Result buffer: MAX_LEN words of 32 bits, one synchronous write port and
// one synchronous read port with 1-cycle read latency.
//   clk, rst      : clock, sync active-high reset (clears read register only)
//   we/waddr/wdata: write port
//   raddr/rdata   : read port, rdata = mem[raddr] one cycle later
// ---------------------------------------------------------------------------
module seq_word_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register drives the bus write data, so it is cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mm_job_sequencer.sv
// ---------------------------------------------------------------------------
// mm_job_sequencer
// Reads N words from SRC_BASE over Avalon-MM, streams them to a datapath,
// collects the datapath results and writes them back to DST_BASE.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   command_port    : [0] req (level), [15:8] job length N
//   status_port     : [0] ack, [1] busy, [2] err
//   mm              : Avalon-MM master (mm_job_sequencer_if.master)
//   dp_start        : one-cycle datapath clear pulse at job start
//   dp_in_valid/data: word sent to the datapath
//   dp_out_valid/data: result returned by the datapath
// Build option: define BYTE_SWAP_EN to byte-reverse read data before the
// datapath and write data before the bus.
// ---------------------------------------------------------------------------
module mm_job_sequencer
    import mm_job_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int MAX_LEN    = 16,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 32,
    parameter int DP_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          command_port,
    output logic [31:0]          status_port,
    mm_job_sequencer_if.master   mm,
    output logic                 dp_start,
    output logic                 dp_in_valid,
    output logic [31:0]          dp_in_data,
    input  logic                 dp_out_valid,
    input  logic [31:0]          dp_out_data
);

    localparam int IDX_W  = $clog2(MAX_LEN + 1);
    localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMO_W  = $clog2(DP_TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DP_TIMEOUT - 1);
    localparam logic [7:0]        MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [ADDR_W-1:0] SRC_A     = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A     = ADDR_W'(DST_BASE);

    function automatic logic [31:0] swap_word(input logic [31:0] w);
`ifdef BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Word index to byte address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
        logic [ADDR_W-1:0] off;
        off = ADDR_W'(idx);
        return base + (off << 2);
    endfunction

    seq_state_t        state_q, state_d;
    logic [IDX_W-1:0]  len_q, len_d, i_q, i_d, r_q, r_d, j_q, j_d;
    logic [TMO_W-1:0]  tcnt_q, tcnt_d;
    logic              ack_q, ack_d, busy_q, busy_d, err_q, err_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              dp_start_d, dp_in_valid_d;
    logic [31:0]       dp_in_data_d;
    logic [31:0]       buf_rdata;

    logic              req, len_ok, rd_acc, wr_acc, rd_last, wr_last;
    logic              collecting, dp_take, dp_over, timeout;
    logic [7:0]        n_cmd;
    logic [IDX_W-1:0]  j_next;
    logic              unused_cmd;

    assign req        = command_port[CMD_REQ];
    assign n_cmd      = command_port[CMD_LEN_MSB:CMD_LEN_LSB];
    assign unused_cmd = ^{command_port[31:CMD_LEN_MSB+1], command_port[CMD_LEN_LSB-1:CMD_REQ+1]};
    assign len_ok     = (n_cmd != 8'd0) && (n_cmd <= MAX_LEN_B);

    assign rd_acc     = (state_q == S_READ)  && rd_q && !mm.master_waitrequest;
    assign wr_acc     = (state_q == S_WRITE) && wr_q && !mm.master_waitrequest;
    assign rd_last    = rd_acc && ((i_q + IDX_ONE) == len_q);
    assign j_next     = j_q + IDX_ONE;
    assign wr_last    = wr_acc && (j_next == len_q);
    assign collecting = (state_q == S_READ) || (state_q == S_FLUSH);
    assign dp_take    = collecting && dp_out_valid && (r_q != len_q);
    assign dp_over    = collecting && dp_out_valid && (r_q == len_q);
    assign timeout    = (state_q == S_FLUSH) && (r_q != len_q) && (tcnt_q == TMO_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req) state_d = len_ok ? S_READ : S_DONE;
            S_READ:  if (rd_last) state_d = S_FLUSH;
            S_FLUSH: begin
                if (r_q == len_q)  state_d = S_WRITE;
                else if (timeout)  state_d = S_DONE;
            end
            S_WRITE: if (wr_last) state_d = S_DONE;
            S_DONE:  if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / counter next values; everything below is registered.
    always_comb begin
        len_d         = len_q;
        i_d           = i_q;
        r_d           = r_q;
        j_d           = j_q;
        tcnt_d        = tcnt_q;
        ack_d         = ack_q;
        busy_d        = busy_q;
        err_d         = err_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        addr_d        = addr_q;
        dp_start_d    = 1'b0;
        dp_in_valid_d = 1'b0;
        dp_in_data_d  = dp_in_data;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    len_d  = IDX_W'(n_cmd);
                    i_d    = '0;
                    r_d    = '0;
                    j_d    = '0;
                    tcnt_d = '0;
                    err_d  = !len_ok;
                    if (len_ok) begin
                        busy_d     = 1'b1;
                        dp_start_d = 1'b1;
                        rd_d       = 1'b1;
                        addr_d     = SRC_A;
                    end else begin
                        ack_d      = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rd_acc) begin
                    dp_in_valid_d = 1'b1;
                    dp_in_data_d  = swap_word(mm.master_readdata);
                    i_d           = i_q + IDX_ONE;
                    addr_d        = addr_of(SRC_A, i_q + IDX_ONE);
                end
                if (rd_last) begin
                    rd_d   = 1'b0;
                    tcnt_d = '0;
                end
            end
            S_FLUSH: begin
                if (r_q == len_q) begin
                    wr_d   = 1'b1;
                    addr_d = DST_A;
                end else if (timeout) begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                    ack_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TMO_ONE;
                end
            end
            S_WRITE: begin
                if (wr_acc) begin
                    j_d    = j_next;
                    addr_d = addr_of(DST_A, j_next);
                end
                if (wr_last) begin
                    wr_d   = 1'b0;
                    busy_d = 1'b0;
                    ack_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (!req) ack_d = 1'b0;
            end
            default: ;
        endcase
        if (dp_take) r_d   = r_q + IDX_ONE;
        if (dp_over) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            i_q         <= '0;
            r_q         <= '0;
            j_q         <= '0;
            tcnt_q      <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            dp_start    <= 1'b0;
            dp_in_valid <= 1'b0;
            dp_in_data  <= '0;
        end else begin
            len_q       <= len_d;
            i_q         <= i_d;
            r_q         <= r_d;
            j_q         <= j_d;
            tcnt_q      <= tcnt_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dp_start    <= dp_start_d;
            dp_in_valid <= dp_in_valid_d;
            dp_in_data  <= dp_in_data_d;
        end
    end

    // Read address runs one word ahead of an accepted write so the buffer's
    // registered output already holds the next word when j advances; outside
    // WRITE it sits on word 0, which primes the first write.
    seq_word_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (BUF_AW)
    ) u_buf (
        .clk   (clk),
        .rst   (reset),
        .we    (dp_take),
        .waddr (BUF_AW'(r_q)),
        .wdata (dp_out_data),
        .raddr ((state_q == S_WRITE) ? BUF_AW'(wr_acc ? j_next : j_q) : '0),
        .rdata (buf_rdata)
    );

    assign mm.master_address   = addr_q;
    assign mm.master_read      = rd_q;
    assign mm.master_write     = wr_q;
    assign mm.master_writedata = swap_word(buf_rdata);
    assign mm.master_byteen    = 4'b1111;

    always_comb begin
        status_port            = '0;
        status_port[STAT_ACK]  = ack_q;
        status_port[STAT_BUSY] = busy_q;
        status_port[STAT_ERR]  = err_q;
    end

endmodule

// File: tb/tb_mm_job_sequencer.sv
module tb_mm_job_sequencer;

    logic        clk;
    logic        reset;
    logic [31:0] command_port;
    logic [31:0] status_port;
    logic        dp_start;
    logic        dp_in_valid;
    logic [31:0] dp_in_data;
    logic        dp_out_valid;
    logic [31:0] dp_out_data;

    mm_job_sequencer_if #(.ADDR_W(10)) mm ();

    mm_job_sequencer #(
        .ADDR_W     (10),
        .MAX_LEN    (16),
        .SRC_BASE   (0),
        .DST_BASE   (32),
        .DP_TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .command_port (command_port),
        .status_port  (status_port),
        .mm           (mm),
        .dp_start     (dp_start),
        .dp_in_valid  (dp_in_valid),
        .dp_in_data   (dp_in_data),
        .dp_out_valid (dp_out_valid),
        .dp_out_data  (dp_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory slave and datapath models
    logic [31:0] src_mem [16];
    int          wait_cfg;
    int          wcnt = 0;
    logic        echo_en;
    int          rd_n = 0;
    int          wr_n = 0;
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    int          stab_viol = 0;
    int          ovl = 0;
    logic        prev_wait = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [9:0]  prev_addr = '0;
    logic [31:0] prev_wdata = '0;

    always_comb begin
        mm.master_waitrequest = (mm.master_read || mm.master_write) && (wcnt < wait_cfg);
        mm.master_readdata    = src_mem[mm.master_address[5:2]];
    end

    always @(posedge clk) begin
        dp_out_valid <= echo_en && dp_in_valid;
        dp_out_data  <= dp_in_data;
        if ((mm.master_read || mm.master_write) && mm.master_waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (mm.master_read && !mm.master_waitrequest) rd_n <= rd_n + 1;
        if (mm.master_write && !mm.master_waitrequest) begin
            wr_addr_log[wr_n] <= 32'(mm.master_address);
            wr_data_log[wr_n] <= mm.master_writedata;
            wr_n <= wr_n + 1;
        end
        if (prev_wait && !reset) begin
            if (mm.master_address !== prev_addr || mm.master_read !== prev_rd ||
                mm.master_write !== prev_wr || (prev_wr && mm.master_writedata !== prev_wdata))
                stab_viol <= stab_viol + 1;
        end
        if (mm.master_read && mm.master_write) ovl <= ovl + 1;
        prev_wait  <= (mm.master_read || mm.master_write) && mm.master_waitrequest;
        prev_rd    <= mm.master_read;
        prev_wr    <= mm.master_write;
        prev_addr  <= mm.master_address;
        prev_wdata <= mm.master_writedata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] cmd(input logic [7:0] n);
        return {16'h0, n, 8'h01};
    endfunction

    task automatic wait_ack(input int limit, output int cycles);
        cycles = 0;
        while (!status_port[0] && cycles < limit) begin
            step();
            cycles++;
        end
        chk("ack_seen", {31'b0, status_port[0]}, 32'd1);
    endtask

    int cyc;
    int rb;
    int wb;
    int k;

    initial begin
        reset        = 1'b1;
        command_port = '0;
        wait_cfg     = 0;
        echo_en      = 1'b1;
        for (int a = 0; a < 16; a++) src_mem[a] = 32'(a + 1);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        chk("rst_status", status_port, 32'd0);
        chk("rst_strobes", {30'b0, mm.master_read, mm.master_write}, 32'd0);
        chk("rst_byteen", {28'b0, mm.master_byteen}, 32'hf);
        chk("rst_addr", 32'(mm.master_address), 32'd0);
        chk("rst_dp", {30'b0, dp_start, dp_in_valid}, 32'd0);
        reset = 1'b0;
        step();

        // N=4, no wait states, echo datapath
        rb = rd_n; wb = wr_n;
        command_port = cmd(8'd4);
        step();
        chk("a_status_busy", status_port, 32'h2);
        chk("a_dp_start", {31'b0, dp_start}, 32'd1);
        chk("a_read", {31'b0, mm.master_read}, 32'd1);
        chk("a_addr0", 32'(mm.master_address), 32'd0);
        wait_ack(200, cyc);
        chk("a_status_done", status_port, 32'h1);
        chk("a_reads", 32'(rd_n - rb), 32'd4);
        chk("a_writes", 32'(wr_n - wb), 32'd4);
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("a_waddr%0d", n), wr_addr_log[wb + n], 32'(32 + 4 * n));
            chk($sformatf("a_wdata%0d", n), wr_data_log[wb + n], 32'(n + 1));
        end
        command_port = '0;
        step();
        chk("a_ack_clear", status_port, 32'h0);

        // N=3 with 3 wait cycles on every transfer
        wait_cfg = 3;
        src_mem[0] = 32'd10; src_mem[1] = 32'd20; src_mem[2] = 32'd30;
        rb = rd_n; wb = wr_n;
        command_port = cmd(8'd3);
        wait_ack(400, cyc);
        chk("b_status", status_port, 32'h1);
        chk("b_reads", 32'(rd_n - rb), 32'd3);
        chk("b_writes", 32'(wr_n - wb), 32'd3);
        chk("b_wdata0", wr_data_log[wb], 32'd10);
        chk("b_wdata1", wr_data_log[wb + 1], 32'd20);
        chk("b_wdata2", wr_data_log[wb + 2], 32'd30);
        chk("b_waddr2", wr_addr_log[wb + 2], 32'd40);
        chk("b_stable", 32'(stab_viol), 32'd0);
        command_port = '0;
        wait_cfg = 0;
        step();

        // N=0 and N=17 are rejected without bus traffic
        rb = rd_n; wb = wr_n;
        command_port = cmd(8'd0);
        step();
        chk("n0_status", status_port, 32'h5);
        chk("n0_strobes", {30'b0, mm.master_read, mm.master_write}, 32'd0);
        command_port = '0;
        step();
        chk("n0_err_held", status_port, 32'h4);
        command_port = cmd(8'd17);
        step();
        chk("n17_status", status_port, 32'h5);
        chk("n17_strobes", {30'b0, mm.master_read, mm.master_write}, 32'd0);
        command_port = '0;
        step();
        chk("n_bad_traffic", 32'((rd_n - rb) + (wr_n - wb)), 32'd0);

        // N=2, datapath silent -> timeout after 64 FLUSH cycles
        echo_en = 1'b0;
        rb = rd_n; wb = wr_n;
        command_port = cmd(8'd2);
        wait_ack(200, cyc);
        chk("d_cycles", 32'(cyc), 32'd67);
        chk("d_status", status_port, 32'h5);
        chk("d_reads", 32'(rd_n - rb), 32'd2);
        chk("d_writes", 32'(wr_n - wb), 32'd0);
        command_port = '0;
        echo_en = 1'b1;
        step();

        // Reset during the second write, then a clean job
        for (int a = 0; a < 4; a++) src_mem[a] = 32'(a + 1);
        wb = wr_n;
        command_port = cmd(8'd4);
        k = 0;
        while (!(mm.master_write && wr_n == wb + 1) && k < 200) begin
            step();
            k++;
        end
        chk("e_second_write", {31'b0, mm.master_write}, 32'd1);
        reset = 1'b1;
        command_port = '0;
        step();
        chk("e_rst_strobes", {30'b0, mm.master_read, mm.master_write}, 32'd0);
        chk("e_rst_status", status_port, 32'd0);
        chk("e_rst_dpvalid", {31'b0, dp_in_valid}, 32'd0);
        reset = 1'b0;
        step();
        wb = wr_n;
        command_port = cmd(8'd2);
        wait_ack(200, cyc);
        chk("f_status", status_port, 32'h1);
        chk("f_writes", 32'(wr_n - wb), 32'd2);
        chk("f_wdata0", wr_data_log[wb], 32'd1);
        chk("f_wdata1", wr_data_log[wb + 1], 32'd2);
        chk("f_waddr1", wr_addr_log[wb + 1], 32'd36);
        command_port = '0;
        step();

        // Byte ordering through the datapath and back
        src_mem[0] = 32'h11223344;
        wb = wr_n;
        command_port = cmd(8'd1);
        k = 0;
        while (!dp_in_valid && k < 50) begin
            step();
            k++;
        end
        chk("g_dp_valid", {31'b0, dp_in_valid}, 32'd1);
`ifdef BYTE_SWAP_EN
        chk("g_dp_data", dp_in_data, 32'h44332211);
`else
        chk("g_dp_data", dp_in_data, 32'h11223344);
`endif
        wait_ack(200, cyc);
        chk("g_wdata", wr_data_log[wb], 32'h11223344);
        chk("g_waddr", wr_addr_log[wb], 32'd32);
        command_port = '0;
        step();

        chk("no_overlap", 32'(ovl), 32'd0);
        chk("stable_all", 32'(stab_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
